// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the block-RAM port arbiter and its RAM wrapper.
package bram_port_arbiter_pkg;

  localparam int MEM_DEPTH  = 2048;
  localparam int MEM_ADDR_W = 11;
  localparam int MEM_DATA_W = 32;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// One requester's request/response channel into the shared block RAM.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 11
) ();
  import bram_port_arbiter_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [MEM_DATA_W-1:0] req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [MEM_DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or m1-wins when fixed_m1 is set.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       fixed_m1,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      if (fixed_m1 || !last_grant) grant = 2'b10;
      else                         grant = 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port 2048x32 BRAM between fetch (m0) and data (m1) requesters,
// with an optional post-reset zero-fill and a one-deep buffered read response.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int DEPTH          = MEM_DEPTH,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int ARB_MODE       = ARB_RR,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_port_arbiter_if.slave    m0,
  bram_port_arbiter_if.slave    m1,
  output logic                  mem_ce,
  output logic                  mem_oce,
  output logic                  mem_wre,
  output logic [ADDR_W-1:0]     mem_ad,
  output logic [MEM_DATA_W-1:0] mem_din,
  output logic [3:0]            mem_byte_en,
  input  logic [MEM_DATA_W-1:0] mem_dout,
  output logic                  clear_busy
);

  state_e                state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic                  resp_pend;
  logic                  resp_owner;
  logic                  resp_fresh;
  logic [MEM_DATA_W-1:0] hold;

  logic                  owner_ready;
  logic                  stall;
  logic                  run;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  sel_we;
  logic                  rd_grant;
  logic [ADDR_W-1:0]     sel_addr;
  logic [MEM_DATA_W-1:0] sel_wdata;
  logic [3:0]            sel_wstrb;
  logic [MEM_DATA_W-1:0] resp_data;

  // A response the owner will not take this cycle freezes the RAM port for everyone.
  assign owner_ready = resp_owner ? m1.resp_ready : m0.resp_ready;
  assign stall       = resp_pend && !owner_ready;
  assign run         = (state == ST_RUN) && !reset;
  assign elig        = {m1.req_valid, m0.req_valid} & {2{run && !stall}};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .fixed_m1 (ARB_MODE == ARB_FIXED),
    .req      (elig),
    .grant    (grant)
  );

  assign m0.req_ready = grant[0];
  assign m1.req_ready = grant[1];

  // Grants are one-hot, so grant[1] alone picks the winning request.
  assign sel_we    = grant[1] ? m1.req_we    : m0.req_we;
  assign sel_addr  = grant[1] ? m1.req_addr  : m0.req_addr;
  assign sel_wdata = grant[1] ? m1.req_wdata : m0.req_wdata;
  assign sel_wstrb = grant[1] ? m1.req_wstrb : m0.req_wstrb;
  assign rd_grant  = (|grant) && !sel_we;

  // First response cycle passes RAM data straight through; later stall cycles use the copy.
  assign resp_data     = resp_fresh ? mem_dout : hold;
  assign m0.resp_valid = resp_pend && !resp_owner;
  assign m1.resp_valid = resp_pend && resp_owner;
  assign m0.resp_rdata = resp_data;
  assign m1.resp_rdata = resp_data;

  assign clear_busy = (state == ST_CLEAR);
  assign mem_oce    = 1'b1;

  always_comb begin
    mem_ce      = 1'b0;
    mem_wre     = 1'b0;
    mem_ad      = '0;
    mem_din     = '0;
    mem_byte_en = '0;
    if (state == ST_CLEAR && !reset) begin
      mem_ce      = 1'b1;
      mem_wre     = 1'b1;
      mem_ad      = clr_cnt;
      mem_byte_en = 4'hF;
    end else if (|grant) begin
      mem_ce      = 1'b1;
      mem_wre     = sel_we;
      mem_ad      = sel_addr;
      mem_din     = sel_wdata;
      mem_byte_en = sel_we ? sel_wstrb : 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt    <= '0;
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
      resp_fresh <= 1'b0;
      hold       <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
      end
      if (resp_fresh) hold <= mem_dout;
      resp_fresh <= 1'b0;
      if (rd_grant) begin
        resp_pend  <= 1'b1;
        resp_owner <= grant[1];
        resp_fresh <= 1'b1;
      end else if (resp_pend && owner_ready) begin
        resp_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a reference memory/response model checked every
// cycle, plus literal expectations for clear length, read data, grant counts and stalls.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_arbiter_if m0_if ();
  bram_port_arbiter_if m1_if ();
  bram_port_arbiter_if f0_if ();
  bram_port_arbiter_if f1_if ();

  logic        mem_ce, mem_oce, mem_wre, clear_busy;
  logic [10:0] mem_ad;
  logic [31:0] mem_din, mem_dout;
  logic [3:0]  mem_byte_en;
  logic        f_mem_ce, f_mem_oce, f_mem_wre, f_clear_busy;
  logic [10:0] f_mem_ad;
  logic [31:0] f_mem_din, f_mem_dout;
  logic [3:0]  f_mem_byte_en;

  bram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(11), .ARB_MODE(0), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(rst), .m0(m0_if), .m1(m1_if),
    .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_ad(mem_ad),
    .mem_din(mem_din), .mem_byte_en(mem_byte_en), .mem_dout(mem_dout),
    .clear_busy(clear_busy)
  );

  bram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(11), .ARB_MODE(1), .CLEAR_ON_RESET(0)) dut_fx (
    .clk(clk), .reset(rst), .m0(f0_if), .m1(f1_if),
    .mem_ce(f_mem_ce), .mem_oce(f_mem_oce), .mem_wre(f_mem_wre), .mem_ad(f_mem_ad),
    .mem_din(f_mem_din), .mem_byte_en(f_mem_byte_en), .mem_dout(f_mem_dout),
    .clear_busy(f_clear_busy)
  );

  // Block RAM stand-in: registered read, byte-masked write; seeded with garbage first.
  logic [31:0] ram [DEPTH];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA5A5_0000 | i;
      seeded <= 1'b1;
    end else if (mem_ce) begin
      if (mem_wre) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) ram[mem_ad][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= ram[mem_ad];
      end
    end
  end

  // The fixed-priority instance only needs an address echo for its reads.
  always @(posedge clk)
    if (f_mem_ce && !f_mem_wre) f_mem_dout <= {21'b0, f_mem_ad};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  // Reference model: memory contents, clear progress, pending response, tie-break history.
  logic [31:0] ref_mem [DEPTH];
  bit          md_clear = 1'b1;
  int          md_cnt   = 0;
  bit          md_last  = 1'b1;
  bit          md_pend  = 1'b0;
  bit          md_owner = 1'b0;
  logic [31:0] md_data  = '0;

  task automatic model_step();
    bit          own_rdy, stall, el0, el1, g0, g1, we;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [48:0] exp_mem;
    if (rst) begin
      check("rst_ready", {m1_if.req_ready, m0_if.req_ready}, 0);
      check("rst_ce_wre", {mem_ce, mem_wre}, 0);
      md_clear = 1'b1; md_cnt = 0; md_last = 1'b1; md_pend = 1'b0;
    end else if (md_clear) begin
      check("clr_busy", clear_busy, 1);
      check("clr_mem", {mem_ce, mem_wre, mem_byte_en, mem_ad, mem_din},
            {1'b1, 1'b1, 4'hF, 11'(md_cnt), 32'h0});
      check("clr_ready", {m1_if.req_ready, m0_if.req_ready}, 0);
      check("clr_resp", {m1_if.resp_valid, m0_if.resp_valid}, 0);
      ref_mem[md_cnt] = 32'h0;
      md_cnt++;
      if (md_cnt == DEPTH) md_clear = 1'b0;
    end else begin
      own_rdy = md_owner ? m1_if.resp_ready : m0_if.resp_ready;
      stall   = md_pend && !own_rdy;
      el0     = m0_if.req_valid && !stall;
      el1     = m1_if.req_valid && !stall;
      g1      = (el0 && el1) ? (md_last == 1'b0) : el1;
      g0      = (el0 || el1) && !g1;
      check("run_ready", {m1_if.req_ready, m0_if.req_ready}, {g1, g0});
      we = g1 ? m1_if.req_we    : m0_if.req_we;
      a  = g1 ? m1_if.req_addr  : m0_if.req_addr;
      d  = g1 ? m1_if.req_wdata : m0_if.req_wdata;
      s  = g1 ? m1_if.req_wstrb : m0_if.req_wstrb;
      exp_mem = (g0 || g1) ? {1'b1, we, (we ? s : 4'hF), a, (we ? d : 32'h0)} : '0;
      if (!(g0 || g1) || we) check("run_mem", {mem_ce, mem_wre, mem_byte_en, mem_ad, mem_din}, exp_mem);
      else check("run_mem_rd", {mem_ce, mem_wre, mem_byte_en, mem_ad}, exp_mem[48:32]);
      check("run_busy_oce", {clear_busy, mem_oce}, 2'b01);
      check("run_resp_valid", {m1_if.resp_valid, m0_if.resp_valid},
            {md_pend && md_owner, md_pend && !md_owner});
      if (md_pend) check("run_rdata", md_owner ? m1_if.resp_rdata : m0_if.resp_rdata, md_data);
      if (g0 || g1) begin
        md_last = g1;
        if (we) ref_mem[a] = merge(ref_mem[a], d, s);
      end
      if ((g0 || g1) && !we) begin
        md_pend = 1'b1; md_owner = g1; md_data = ref_mem[a];
      end else if (md_pend && own_rdy) begin
        md_pend = 1'b0;
      end
    end
  endtask

  // Output snapshot taken on the falling edge of every cycle.
  logic        s_ready0, s_ready1, s_valid0, s_valid1, s_ce, s_busy;
  logic [31:0] s_rdata0, s_rdata1;
  logic [10:0] s_ad;
  logic        f_ready0, f_ready1, f_valid1, f_busy, f_oce;
  logic [31:0] f_rdata1;

  task automatic tick();
    @(negedge clk);
    s_ready0 = m0_if.req_ready;  s_ready1 = m1_if.req_ready;
    s_valid0 = m0_if.resp_valid; s_valid1 = m1_if.resp_valid;
    s_rdata0 = m0_if.resp_rdata; s_rdata1 = m1_if.resp_rdata;
    s_ce = mem_ce; s_ad = mem_ad; s_busy = clear_busy;
    f_ready0 = f0_if.req_ready; f_ready1 = f1_if.req_ready;
    f_valid1 = f1_if.resp_valid; f_rdata1 = f1_if.resp_rdata;
    f_busy = f_clear_busy; f_oce = f_mem_oce;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input bit v, input bit we, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (p) begin
      m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = a;
      m1_if.req_wdata = d; m1_if.req_wstrb = s;
    end else begin
      m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = a;
      m0_if.req_wdata = d; m0_if.req_wstrb = s;
    end
  endtask

  task automatic do_write(input bit p, input logic [10:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    bit got = 1'b0;
    set_req(p, 1'b1, 1'b1, a, d, s);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = p ? s_ready1 : s_ready0;
    end
    check("wr_grant", got, 1);
    set_req(p, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
  endtask

  task automatic do_read(input bit p, input logic [10:0] a, output logic [31:0] d,
                         output bit on_time);
    bit got = 1'b0;
    set_req(p, 1'b1, 1'b0, a, 32'h0, 4'h0);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = p ? s_ready1 : s_ready0;
    end
    check("rd_grant", got, 1);
    set_req(p, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    tick();
    on_time = p ? s_valid1 : s_valid0;
    d       = p ? s_rdata1 : s_rdata0;
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!s_busy) break;
      if (n == 0) check({tag, "_first_ad"}, s_ad, 11'h000);
      n++;
      if (n == DEPTH) check({tag, "_last_ad"}, s_ad, 11'h7FF);
    end
    check({tag, "_len"}, n, DEPTH);
  endtask

  initial begin
    int          g0, g1, nce, nrdy;
    logic [31:0] d;
    bit          ok;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    m0_if.resp_ready = 1'b1; m1_if.resp_ready = 1'b1;
    f0_if.req_valid = 1'b0; f0_if.req_we = 1'b0; f0_if.req_addr = 11'h0AA;
    f0_if.req_wdata = 32'h0; f0_if.req_wstrb = 4'h0; f0_if.resp_ready = 1'b1;
    f1_if.req_valid = 1'b0; f1_if.req_we = 1'b0; f1_if.req_addr = 11'h055;
    f1_if.req_wdata = 32'h0; f1_if.req_wstrb = 4'h0; f1_if.resp_ready = 1'b1;
    tick();
    tick();

    // Zero-fill with m0 requesting throughout; it must not be served until the fill ends.
    set_req(0, 1'b1, 1'b0, 11'h000, 32'h0, 4'h0);
    rst  = 1'b0;
    nrdy = 0;
    count_clear("clr");
    check("clr_exit_grant", s_ready0, 1);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    tick();
    check("rd000_valid", s_valid0, 1);
    check("rd000_data", s_rdata0, 32'h0000_0000);
    do_read(0, 11'h7FF, d, ok);
    check("rd7ff_lat1", ok, 1);
    check("rd7ff_data", d, 32'h0000_0000);

    // Byte-enable merge, an all-zero strobe, and write-then-read on consecutive cycles.
    do_write(1, 11'h123, 32'hDEAD_BEEF, 4'hF);
    do_write(1, 11'h123, 32'h0000_00AA, 4'b0001);
    do_read(0, 11'h123, d, ok);
    check("merge_lat1", ok, 1);
    check("merge_data", d, 32'hDEAD_BEAA);
    do_write(1, 11'h123, 32'h5555_5555, 4'h0);
    do_read(0, 11'h123, d, ok);
    check("zero_strb_data", d, 32'hDEAD_BEAA);
    do_write(1, 11'h010, 32'h1122_3344, 4'hF);
    do_read(0, 11'h010, d, ok);
    check("wr_then_rd", d, 32'h1122_3344);

    // Both ports reading back-to-back: strict alternation, RAM busy every cycle.
    set_req(0, 1'b1, 1'b0, 11'h123, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
    g0 = 0; g1 = 0; nce = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      g0 += int'(s_ready0); g1 += int'(s_ready1); nce += int'(s_ce);
    end
    check("rr_m0_grants", g0, 50);
    check("rr_m1_grants", g1, 50);
    check("rr_ce_cycles", nce, 100);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    tick();

    // m0 holds off its read response; m1 waits and is granted as soon as m0 takes it.
    m0_if.resp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 11'h010, 32'h0, 4'h0);
    tick();
    check("stall_m0_grant", s_ready0, 1);
    set_req(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 11'h123, 32'h0, 4'h0);
    nrdy = 0; nce = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rdata", s_rdata0, 32'h1122_3344);
      nrdy += int'(s_ready1); nce += int'(s_ce);
    end
    check("stall_m1_ready", nrdy, 0);
    check("stall_ce", nce, 0);
    m0_if.resp_ready = 1'b1;
    tick();
    check("release_m1_grant", s_ready1, 1);
    check("release_m0_valid", s_valid0, 1);
    set_req(1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    tick();
    check("release_m1_valid", s_valid1, 1);
    check("release_m1_data", s_rdata1, 32'hDEAD_BEAA);

    // Fixed-priority instance: m1 takes every contended cycle; no fill without CLEAR_ON_RESET.
    check("fx_no_clear", f_busy, 0);
    check("fx_oce", f_oce, 1);
    f0_if.req_valid = 1'b1; f1_if.req_valid = 1'b1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      g0 += int'(f_ready0); g1 += int'(f_ready1);
    end
    check("fx_m1_grants", g1, 10);
    check("fx_m0_grants", g0, 0);
    check("fx_m1_rdata", {f_valid1, f_rdata1}, {1'b1, 32'h0000_0055});
    f0_if.req_valid = 1'b0; f1_if.req_valid = 1'b0;

    // Pending response is dropped by reset; a reset mid-fill restarts it from address 0.
    m0_if.resp_ready = 1'b0;
    do_read(0, 11'h7FF, d, ok);
    check("pre_rst_pending", ok, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_if.resp_ready = 1'b1;
    tick();
    check("rst_resp_cleared", s_valid0, 0);
    check("refill_ad0", s_ad, 11'h000);
    for (int i = 1; i < 700; i++) tick();
    check("refill_ad699", s_ad, 11'd699);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("refill");
    do_read(1, 11'h123, d, ok);
    check("refill_zeroed", d, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-requester arbiter and sequencer for the 2048x32 single-port block RAM with byte enables. Port m0 is instruction fetch and port m1 is the data port. The block shares the RAM's single port between them using round-robin (or fixed-priority) arbitration, with valid/ready handshakes and buffered read responses. After reset it optionally zero-fills the whole RAM before accepting any request.

Parameters:
DEPTH, 2048, number of 32-bit words in the RAM.
ADDR_W, 11, word-address width; equals log2(DEPTH).
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with m1 winning.
CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = go straight to RUN.

Ports:
clk  in  1  single clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
mX_req_valid  in  1  request valid (X = 0, 1; the same set of ports exists for each requester)
mX_req_ready  out  1  request accepted this cycle (the grant)
mX_req_we  in  1  1 = write, 0 = read
mX_req_addr  in  ADDR_W  word address
mX_req_wdata  in  32  write data
mX_req_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
mX_resp_valid  out  1  read data valid
mX_resp_ready  in  1  requester accepts the read data
mX_resp_rdata  out  32  read data
mem_ce  out  1  RAM clock enable
mem_oce  out  1  RAM output clock enable; tied to 1
mem_wre  out  1  RAM write enable
mem_ad  out  ADDR_W  RAM address
mem_din  out  32  RAM write data
mem_byte_en  out  4  RAM byte enables
mem_dout  in  32  RAM read data; valid one cycle after a read with ce=1
clear_busy  out  1  high while the zero-fill is in progress

Behaviour:
- Reset: state = CLEAR if CLEAR_ON_RESET, else RUN. clr_cnt = 0. last_grant = 1, so m0 wins the first tie. All resp_valid = 0 and rdata/hold registers = 0.
- While reset is high: mX_req_ready = 0 and mem_ce = mem_wre = 0.
- CLEAR state:
  - Outputs: mem_ce = 1, mem_wre = 1, mem_byte_en = 4'hF, mem_din = 0, mem_ad = clr_cnt. Both req_ready = 0. clear_busy = 1.
  - clr_cnt increments each cycle. After the cycle that writes DEPTH-1, the state moves to RUN (DEPTH cycles total).
  - Reset asserted mid-clear restarts the fill at address 0.
- RUN state, grant rules:
  - stall = any mX_resp_valid && !mX_resp_ready.
  - Eligible = mX_req_valid && !stall.
  - Round-robin: if both are eligible, grant the port not equal to last_grant. A single eligible port is always granted.
  - ARB_MODE = 1: m1 always wins a tie.
  - Grant is combinational: mX_req_ready = grant_X.
  - last_grant updates only on a grant.
- RUN state, memory side:
  - Memory outputs are driven combinationally from the granted request: mem_ce = 1, mem_wre = we, mem_ad = addr, mem_din = wdata, mem_byte_en = wstrb for writes and 4'hF for reads.
  - With no grant: mem_ce = 0, mem_wre = 0, and the address/data/byte-enable outputs are 0.
- Writes:
  - Complete at the grant cycle; there is no response.
  - wstrb = 0 is still granted and leaves the RAM unchanged.
- Reads:
  - Granted in cycle N. In cycle N+1, the owner's resp_valid = 1 and resp_rdata = mem_dout. Read latency is 1.
  - In cycle N+1, mem_dout is also captured into a hold register.
  - If resp_ready is low, resp_rdata comes from the hold register from N+2 onward and resp_valid stays 1. Stall blocks all grants, so mem_ce stays 0.
  - resp_valid clears on the cycle after resp_valid && resp_ready.
  - A grant in the same cycle as the response handshake is allowed, giving a back-to-back read every cycle.
- The response owner is registered alongside the pending flag. At most one read is outstanding.
- A write to address A followed by a read of A in the next cycle returns the new data; the RAM provides this.
- The non-owner's resp_valid is always 0.

Decomposition:
- Shared package: state enum {ST_CLEAR, ST_RUN}, ARB_RR / ARB_FIXED constants, and the ADDR_W / DATA_W constants shared with the RAM wrapper.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with last_grant register and mode input. Everything else stays flat.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, assert m0_req_valid throughout -> clear_busy high for exactly 2048 cycles with mem_ad sweeping 0..2047 at mem_din 0, m0_req_ready 0 throughout. Afterwards, reads of 0x000 and 0x7FF return 0x00000000.
2. m1 writes 0xDEADBEEF to 0x123 with wstrb 4'hF, then 0x000000AA with wstrb 4'b0001. A subsequent m0 read of 0x123 gives resp_valid exactly one cycle after grant with rdata 0xDEADBEAA.
3. Both ports read continuously with resp_ready held 1 -> grants alternate m0, m1, m0, ...; 100 cycles give 50 grants each; mem_ce is 1 every cycle.
4. m0 reads 0x010 (contents 0x11223344) with m0_resp_ready held 0 for 5 cycles while m1_req_valid = 1 -> m0_resp_rdata stays 0x11223344, mem_ce 0 and m1_req_ready 0 during the stall. m1 is granted in the same cycle that m0_resp_ready rises.
5. ARB_MODE=1, both valid for 10 cycles -> m1 granted all 10 cycles, m0 never.
6. Assert reset for one cycle during CLEAR at clr_cnt = 700 -> the fill restarts at address 0 and clear_busy lasts 2048 more cycles. Outstanding resp_valid signals are zero after reset.
